// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage: PC, imem request handshake, IF/ID register
// Holds one returned instruction when memory answers during a load-use stall.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_IC   = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] ID_PC,
    output logic [31:0] ID_IC,
    output logic        ID_valid
);

    typedef enum logic {S_REQ, S_FULL} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] id_pc_n;
    logic [31:0] id_ic_n;
    logic        id_valid_n;
    logic [63:0] buf_pc, buf_pc_n;
    logic [31:0] buf_ic, buf_ic_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            ID_PC    <= 64'h0;
            ID_IC    <= NOP_IC;
            ID_valid <= 1'b0;
            buf_pc   <= 64'h0;
            buf_ic   <= 32'h0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ID_PC    <= id_pc_n;
            ID_IC    <= id_ic_n;
            ID_valid <= id_valid_n;
            buf_pc   <= buf_pc_n;
            buf_ic   <= buf_ic_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_pc_n    = ID_PC;
        id_ic_n    = ID_IC;
        id_valid_n = ID_valid;
        buf_pc_n   = buf_pc;
        buf_ic_n   = buf_ic;
        if (branch_taken) begin
            // Redirect wins over stall and drops any word returned this cycle.
            state_n    = S_REQ;
            pc_n       = {branch_target[63:2], 2'b00};
            id_pc_n    = 64'h0;
            id_ic_n    = NOP_IC;
            id_valid_n = 1'b0;
            buf_pc_n   = 64'h0;
            buf_ic_n   = 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        pc_n = pc + 64'd4;
                        if (stall) begin
                            buf_pc_n = pc;
                            buf_ic_n = imem_rdata;
                            state_n  = S_FULL;
                        end else begin
                            id_pc_n    = pc;
                            id_ic_n    = imem_rdata;
                            id_valid_n = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        id_pc_n    = buf_pc;
                        id_ic_n    = buf_ic;
                        id_valid_n = 1'b1;
                        state_n    = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    // Request drops asynchronously with reset and returns as soon as reset is released.
    assign imem_req  = (state == S_REQ) && !reset;
    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
// Table vectors, hand-written reset/buffer sequences and a randomized run against a queue-based model.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] NOP    = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, imem_ready;
    logic [63:0] branch_target;
    logic [31:0] imem_rdata;
    logic        imem_req, ID_valid;
    logic [63:0] imem_addr, ID_PC;
    logic [31:0] ID_IC;

    int checks = 0;
    int passed = 0;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_IC(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ID_PC(ID_PC), .ID_IC(ID_IC), .ID_valid(ID_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [63:0] a);
        return a[31:0] ^ 32'h8B00_0000;
    endfunction

    // Packed view: {req, addr, id_pc, id_ic, id_valid}
    task automatic check(input string name, input logic [161:0] exp);
        logic [161:0] act;
        act = {imem_req, imem_addr, ID_PC, ID_IC, ID_valid};
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got req=%0b addr=%h id_pc=%h id_ic=%h v=%0b, want req=%0b addr=%h id_pc=%h id_ic=%h v=%0b",
                      name, act[161], act[160:97], act[96:33], act[32:1], act[0],
                      exp[161], exp[160:97], exp[96:33], exp[32:1], exp[0]);
    endtask

    // Behavioural model: a PC, an IF/ID triple and a queue holding at most one buffered fetch.
    logic [63:0] m_pc, m_id_pc;
    logic [31:0] m_id_ic;
    logic        m_id_v;
    logic [95:0] m_buf[$];

    task automatic model_reset();
        m_pc = RST_PC; m_id_pc = 0; m_id_ic = NOP; m_id_v = 0;
        m_buf.delete();
    endtask

    task automatic model_step(input logic st, input logic br, input logic rdy,
                              input logic [63:0] bt, input logic [31:0] rd);
        logic [95:0] e;
        if (br) begin
            m_pc = bt & ~64'h3;
            m_id_pc = 0; m_id_ic = NOP; m_id_v = 0;
            m_buf.delete();
        end else if (m_buf.size() != 0) begin
            if (!st) begin
                e = m_buf.pop_front();
                m_id_pc = e[95:32]; m_id_ic = e[31:0]; m_id_v = 1;
            end
        end else if (rdy) begin
            if (st) m_buf.push_back({m_pc, rd});
            else begin
                m_id_pc = m_pc; m_id_ic = rd; m_id_v = 1;
            end
            m_pc = m_pc + 64'd4;
        end
    endtask

    function automatic logic [161:0] model_exp();
        return {m_buf.size() == 0, m_pc, m_id_pc, m_id_ic, m_id_v};
    endfunction

    // Drive one cycle of inputs, clock, compare against the model.
    task automatic model_cycle(input string name, input logic st, input logic br,
                               input logic rdy, input logic [63:0] bt);
        stall = st; branch_taken = br; imem_ready = rdy; branch_target = bt;
        imem_rdata = rdy ? tag(m_pc) : $urandom;
        model_step(st, br, rdy, bt, imem_rdata);
        @(posedge clk); #1;
        check(name, model_exp());
    endtask

    typedef struct {
        logic        st, br, rdy;
        logic [63:0] bt;
        logic        e_req;
        logic [63:0] e_addr, e_id_pc;
        logic        e_v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic br, input logic rdy, input logic [63:0] bt,
                                input logic e_req, input logic [63:0] e_addr,
                                input logic [63:0] e_id_pc, input logic e_v);
        vec_t v;
        v.st = st; v.br = br; v.rdy = rdy; v.bt = bt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_id_pc = e_id_pc; v.e_v = e_v;
        return v;
    endfunction

    initial begin
        logic [63:0] cur_addr;
        logic [31:0] e_ic;

        //            st br rdy bt                     req addr                    id_pc                   v
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h104,               64'h100,                1));
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h108,               64'h104,                1));
        vecs.push_back(mk(1, 0, 1, 64'h0,                0, 64'h10C,               64'h104,                1));
        vecs.push_back(mk(1, 0, 1, 64'h0,                0, 64'h10C,               64'h104,                1));
        vecs.push_back(mk(1, 0, 0, 64'h0,                0, 64'h10C,               64'h104,                1));
        vecs.push_back(mk(0, 0, 0, 64'h0,                1, 64'h10C,               64'h108,                1));
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h110,               64'h10C,                1));
        vecs.push_back(mk(1, 1, 1, 64'h2003,             1, 64'h2000,              64'h0,                  0));
        vecs.push_back(mk(0, 1, 0, 64'h200,              1, 64'h200,               64'h0,                  0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                1, 64'h200,               64'h0,                  0));
        vecs.push_back(mk(1, 0, 0, 64'h0,                1, 64'h200,               64'h0,                  0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                1, 64'h200,               64'h0,                  0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                1, 64'h200,               64'h0,                  0));
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h204,               64'h200,                1));
        vecs.push_back(mk(0, 1, 1, 64'hFFFFFFFFFFFFFFFC, 1, 64'hFFFFFFFFFFFFFFFC,  64'h0,                  0));
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h0,                 64'hFFFFFFFFFFFFFFFC,   1));
        vecs.push_back(mk(0, 0, 1, 64'h0,                1, 64'h4,                 64'h0,                  1));

        reset = 1; stall = 0; branch_taken = 0; imem_ready = 0;
        branch_target = 0; imem_rdata = 0;
        #2;
        check("reset_hold", {1'b0, RST_PC, 64'h0, NOP, 1'b0});
        #1 reset = 0;
        #1 check("reset_release", {1'b1, RST_PC, 64'h0, NOP, 1'b0});

        cur_addr = RST_PC;
        foreach (vecs[i]) begin
            stall = vecs[i].st; branch_taken = vecs[i].br; imem_ready = vecs[i].rdy;
            branch_target = vecs[i].bt;
            imem_rdata = tag(cur_addr);
            @(posedge clk); #1;
            e_ic = vecs[i].e_v ? tag(vecs[i].e_id_pc) : NOP;
            check($sformatf("vec%0d", i),
                  {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_id_pc, e_ic, vecs[i].e_v});
            cur_addr = vecs[i].e_addr;
        end

        // Enter the buffered state at PC 0x4, then reset between clock edges.
        stall = 1; branch_taken = 0; imem_ready = 1; imem_rdata = tag(64'h4);
        @(posedge clk); #1;
        check("enter_full", {1'b0, 64'h8, 64'h0, tag(64'h0), 1'b1});
        #2 reset = 1;
        #1 check("reset_in_full", {1'b0, RST_PC, 64'h0, NOP, 1'b0});
        #2 reset = 0;
        #1 check("restart_req", {1'b1, RST_PC, 64'h0, NOP, 1'b0});
        model_reset();
        model_cycle("restart_fetch", 0, 0, 1, 64'h0);
        model_cycle("stall_buffer", 1, 0, 1, 64'h0);
        model_cycle("stall_release", 0, 0, 1, 64'h0);
        model_cycle("post_release", 0, 0, 1, 64'h0);

        for (int i = 0; i < 500; i++) begin
            logic [63:0] bt;
            bt = {$urandom, $urandom};
            model_cycle($sformatf("rand%0d", i),
                        $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                        $urandom_range(0, 9) < 6, bt);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
